dif_sample_framer: RTL
======================

// Module: dif_sample_framer
// PURPOSE
//  Frames a free-running ADC sample stream (one 16-bit sample per adc_valid) into WSI
//  write bursts on the dif interface consumed directly by the wideband receiver worker.
//  Elastic FIFO absorbs SThreadBusy back-pressure; samples arriving with FIFO full are
//  dropped and counted. Sits between the ADC capture logic and the receiver's dif port.
// PARAMETERS
//  SAMPLE_W    16  sample width; placed in dif_MData[15:0]
//  BURST_LEN   64  words per message (precise burst), legal 1..4095
//  FIFO_DEPTH  16  sample FIFO entries, power of 2, >=2
//  FIFO_AW     4   log2(FIFO_DEPTH)
// PORTS
//  dif_Clk            in   1   sole clock
//  dif_Reset          in   1   synchronous, active-high reset
//  adc_valid          in   1   sample strobe; cannot be stalled
//  adc_data           in   16  sample
//  enable             in   1   level; 1 = start new bursts
//  dif_MCmd           out  3   3'b000 IDLE, 3'b001 WR
//  dif_MReqLast       out  1   1 on final word of burst
//  dif_MBurstPrecise  out  1   1 whenever MCmd=WR
//  dif_MBurstLength   out  12  BURST_LEN on every WR word
//  dif_MData          out  32  [15:0] sample, [31:16] see CONFIGURATION
//  dif_MReqInfo       out  1   opcode, constant 0 (data)
//  dif_SThreadBusy    in   1   1 = downstream cannot accept a word this cycle
//  overflow_count     out  16  dropped samples, saturates at 16'hFFFF
//  in_burst           out  1   1 while FSM in BURST
// BEHAVIOUR
//  - All dif_* outputs registered. Reset: MCmd=IDLE, MReqLast=0, MBurstPrecise=0,
//    MBurstLength=0, MData=0, MReqInfo=0, overflow_count=0, in_burst=0; FIFO emptied,
//    word counter=0, FSM=IDLE.
//  - FIFO write: adc_valid && !full. adc_valid && full && no read this cycle -> drop,
//    overflow_count+1 (hold at FFFF). Full + simultaneous read -> write accepted, no drop.
//  - Issue condition per cycle: FIFO non-empty && !dif_SThreadBusy && (FSM=BURST ||
//    enable). When met, pop FIFO and register WR word on next edge; otherwise register IDLE
//    (MReqLast=0, MBurstPrecise=0, MBurstLength=0, MData holds).
//  - FSM IDLE -> BURST on first issued word (word_cnt:=1). BURST: word_cnt+1 per issued
//    word; word with word_cnt=BURST_LEN carries MReqLast=1, FSM -> IDLE, word_cnt:=0.
//    BURST_LEN=1: every word is single-word burst with MReqLast=1, FSM stays IDLE.
//  - enable sampled only in IDLE; deassertion mid-burst does not truncate the burst.
//  - FIFO empty mid-burst: IDLE cycles inserted; burst resumes, length unchanged.
//  - Latency: sample written at edge k -> earliest WR word on dif_* after edge k+2.
//  - Order preserved; no sample duplicated or reordered.
//  - Reset mid-burst: burst abandoned without MReqLast; downstream shares dif_Reset.
// CONFIGURATION
//  SEQ_TAG_EN defined: 16-bit seq counter +1 (wrap) on every adc_valid, incl. dropped;
//    stored with sample, output in dif_MData[31:16]; reset to 0. Drops show as tag gaps.
//  SEQ_TAG_EN undefined: dif_MData[31:16]=0; no tag storage in FIFO.
// TESTING
//  1 reset, enable=1, busy=0, 64 samples 0x0000..0x003F back-to-back -> 64 WR words,
//    data in order, all MBurstLength=64/Precise=1, MReqLast only on 0x003F, first WR 2 cyc in.
//  2 busy=1 from reset, 20 samples (DEPTH=16) -> overflow_count=4; release busy ->
//    16 words 0..15 out, no further drops.
//  3 enable 1->0 after 10th word -> burst completes 64 words, then MCmd stays IDLE.
//  4 samples every 3rd cycle -> 2 IDLE cycles between WR words, still one 64-word burst,
//    MReqLast only on 64th.
//  5 dif_Reset at 30th word -> next cycle all outputs reset values; next burst's first
//    word starts new count, MReqLast on its 64th word.
//  6 SEQ_TAG_EN, busy=1, 20 samples, release -> tags 0..15 out; next sample tag 20.

Source files
------------

// File: rtl/dif_sample_framer_if.sv
// dif_sample_framer_if: WSI write-burst signals between the sample framer (master) and the receiver (slave).
interface dif_sample_framer_if;
    logic [2:0]  MCmd;
    logic        MReqLast;
    logic        MBurstPrecise;
    logic [11:0] MBurstLength;
    logic [31:0] MData;
    logic        MReqInfo;
    logic        SThreadBusy;
    modport master (output MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MReqInfo, input SThreadBusy);
    modport slave  (input MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MReqInfo, output SThreadBusy);
endinterface

// File: rtl/dif_sample_framer.sv
// dif_sample_framer: frames an unstallable ADC sample stream into precise WSI write bursts through an elastic FIFO.
// Define SEQ_TAG_EN to carry a 16-bit per-sample sequence tag in dif_MData[31:16].
module dif_sample_framer #(
    parameter int SAMPLE_W   = 16,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                    dif_Clk,
    input  logic                    dif_Reset,
    input  logic                    adc_valid,
    input  logic [SAMPLE_W-1:0]     adc_data,
    input  logic                    enable,
    dif_sample_framer_if.master     dif,
    output logic [15:0]             overflow_count,
    output logic                    in_burst
);
`ifdef SEQ_TAG_EN
    localparam int ENT_W = SAMPLE_W + 16;
`else
    localparam int ENT_W = SAMPLE_W;
`endif
    typedef enum logic {IDLE, BURST} state_t;
    state_t               state;
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [FIFO_AW:0]     wptr, rptr, cnt;
    logic [11:0]          word_cnt, word_nxt;
    logic [ENT_W-1:0]     wr_ent, rd_ent;
    logic [15:0]          tag;
    logic                 wr_q, full, avail, issue, wr, last;
`ifdef SEQ_TAG_EN
    logic [15:0]          seq;
    assign wr_ent = {seq, adc_data};
    assign tag    = rd_ent[ENT_W-1 -: 16];
    always_ff @(posedge dif_Clk)
        seq <= dif_Reset ? 16'h0 : seq + {15'h0, adc_valid};
`else
    assign wr_ent = adc_data;
    assign tag    = 16'h0;
`endif
    assign cnt      = wptr - rptr;
    assign full     = cnt == (FIFO_AW+1)'(FIFO_DEPTH);
    // A sample becomes visible to the reader one cycle after it is written.
    assign avail    = cnt > {{FIFO_AW{1'b0}}, wr_q};
    assign issue    = avail && !dif.SThreadBusy && (state == BURST || enable);
    assign wr       = adc_valid && (!full || issue);
    assign word_nxt = word_cnt + 12'd1;
    assign last     = word_nxt == 12'(BURST_LEN);
    assign rd_ent   = mem[rptr[FIFO_AW-1:0]];
    assign in_burst = state == BURST;
    assign dif.MReqInfo = 1'b0;
    always_ff @(posedge dif_Clk)
        if (wr) mem[wptr[FIFO_AW-1:0]] <= wr_ent;
    always_ff @(posedge dif_Clk) begin
        if (dif_Reset) begin
            state              <= IDLE;
            wptr               <= '0;
            rptr               <= '0;
            wr_q               <= 1'b0;
            word_cnt           <= '0;
            overflow_count     <= 16'h0;
            dif.MCmd           <= 3'b000;
            dif.MReqLast       <= 1'b0;
            dif.MBurstPrecise  <= 1'b0;
            dif.MBurstLength   <= 12'h0;
            dif.MData          <= 32'h0;
        end else begin
            wr_q <= wr;
            if (wr) wptr <= wptr + 1'b1;
            if (issue) rptr <= rptr + 1'b1;
            if (adc_valid && !wr && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'h1;
            dif.MCmd          <= issue ? 3'b001 : 3'b000;
            dif.MReqLast      <= issue && last;
            dif.MBurstPrecise <= issue;
            dif.MBurstLength  <= issue ? 12'(BURST_LEN) : 12'h0;
            if (issue) begin
                dif.MData <= {tag, rd_ent[SAMPLE_W-1:0]};
                state     <= last ? IDLE : BURST;
                word_cnt  <= last ? 12'h0 : word_nxt;
            end
        end
    end
endmodule
